// File: rtl/bcd_field_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_field_renderer
//  Description : On-screen renderer for NUM_FIELDS two-digit BCD fields.
//                Maps each pixel to a scaled 8x16 glyph cell, addresses the
//                shared font ROM, and emits a registered 12-bit RGB value
//                with cursor highlight, blinking and digit blanking.
//                Fixed pixel-to-output latency of three clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_field_renderer #(
    parameter int          NUM_FIELDS   = 3,
    parameter int          X0           = 304,
    parameter int          Y0           = 384,
    parameter int          SCALE        = 2,
    parameter int          FIELD_PITCH  = 48,
    parameter int          CURSOR_BASE  = 6,
    parameter int          BLINK_FRAMES = 30,
    parameter int          LZ_BLANK     = 0,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] HL           = 12'hF00,
    parameter logic [11:0] BG           = 12'h000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    video_on,
    input  logic                    prog_on,
    input  logic                    frame_tick,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic [3:0]              cursor,
    input  logic [8*NUM_FIELDS-1:0] digits,
    output logic [3:0]              rom_char,
    output logic [3:0]              rom_row,
    input  logic [7:0]              rom_data,
    output logic [11:0]             rgb_out,
    output logic                    pixel_hit
);

    // log2(SCALE): glyph column/row come from plain shifts
    localparam int               c_sh         = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int               c_bw         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [10:0]      c_y0         = 11'(Y0);
    localparam logic [10:0]      c_cell_h     = 11'(16 * SCALE);
    localparam logic [c_bw-1:0]  c_blink_last = c_bw'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    // stage 0 (combinational) results
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] y_off;
    logic [10:0] x_off;
    logic        y_in;
    logic        hit0;
    logic        dsel0;
    logic        lz0;
    logic        blank0;
    logic        sel0;
    logic [2:0]  col0;
    logic [3:0]  dig0;
    logic [3:0]  row0;

    // registered state
    logic [3:0]      rom_char_q,    rom_char_d;
    logic [3:0]      rom_row_q,     rom_row_d;
    logic            hit1_q,        hit1_d;
    logic [2:0]      col1_q,        col1_d;
    logic            blank1_q,      blank1_d;
    logic            sel1_q,        sel1_d;
    logic            vid1_q,        vid1_d;
    logic            hit2_q,        hit2_d;
    logic [2:0]      col2_q,        col2_d;
    logic            blank2_q,      blank2_d;
    logic            sel2_q,        sel2_d;
    logic            vid2_q,        vid2_d;
    logic [11:0]     rgb_q,         rgb_d;
    logic            pixel_hit_q,   pixel_hit_d;
    logic [c_bw-1:0] blink_cnt_q,   blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            glyph_bit;

    // Stage 0: locate the pixel within a field/digit cell and pick its digit.
    // Fields never overlap (pitch >= two cells), so at most one field matches.
    always_comb begin
        px     = {1'b0, pixel_x};
        py     = {1'b0, pixel_y};
        y_off  = py - c_y0;
        y_in   = (py >= c_y0) && (py < (c_y0 + c_cell_h));
        row0   = 4'(y_off >> c_sh);
        hit0   = 1'b0;
        dsel0  = 1'b0;
        col0   = 3'd0;
        dig0   = 4'd0;
        sel0   = 1'b0;
        lz0    = 1'b0;
        x_off  = 11'd0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (enable && y_in &&
                (px >= 11'(X0 + k * FIELD_PITCH)) &&
                (px <  11'(X0 + k * FIELD_PITCH + 16 * SCALE))) begin
                hit0  = 1'b1;
                x_off = px - 11'(X0 + k * FIELD_PITCH);
                dsel0 = x_off[c_sh + 3];
                col0  = 3'(x_off >> c_sh);
                dig0  = dsel0 ? digits[8*k +: 4] : digits[8*k+4 +: 4];
                sel0  = prog_on && (int'(cursor) == CURSOR_BASE + k);
                lz0   = (LZ_BLANK != 0) && (k == 0) && !dsel0 && (dig0 == 4'd0);
            end
        end
        blank0 = (dig0 > 4'd9) || lz0;
    end

    // Next-state: pipeline stages 1..3 and the blink counter/phase.
    always_comb begin
        rom_char_d    = hit0 ? dig0 : rom_char_q;
        rom_row_d     = hit0 ? row0 : rom_row_q;
        hit1_d        = hit0;
        col1_d        = col0;
        blank1_d      = blank0;
        sel1_d        = sel0;
        vid1_d        = video_on;
        hit2_d        = hit1_q;
        col2_d        = col1_q;
        blank2_d      = blank1_q;
        sel2_d        = sel1_q;
        vid2_d        = vid1_q;

        glyph_bit     = rom_data[3'd7 - col2_q];
        pixel_hit_d   = vid2_q && hit2_q;
        rgb_d         = BG;
        if (vid2_q && hit2_q && !blank2_q && glyph_bit) begin
            rgb_d = (sel2_q && !blink_phase_q) ? HL : FG;
        end

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if ((BLINK_FRAMES == 0) || !prog_on) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == c_blink_last) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + c_bw'(1);
            end
        end
    end

    // State registers with synchronous reset clearing the whole pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_char_q    <= 4'd0;
            rom_row_q     <= 4'd0;
            hit1_q        <= 1'b0;
            col1_q        <= 3'd0;
            blank1_q      <= 1'b0;
            sel1_q        <= 1'b0;
            vid1_q        <= 1'b0;
            hit2_q        <= 1'b0;
            col2_q        <= 3'd0;
            blank2_q      <= 1'b0;
            sel2_q        <= 1'b0;
            vid2_q        <= 1'b0;
            rgb_q         <= 12'd0;
            pixel_hit_q   <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            rom_char_q    <= rom_char_d;
            rom_row_q     <= rom_row_d;
            hit1_q        <= hit1_d;
            col1_q        <= col1_d;
            blank1_q      <= blank1_d;
            sel1_q        <= sel1_d;
            vid1_q        <= vid1_d;
            hit2_q        <= hit2_d;
            col2_q        <= col2_d;
            blank2_q      <= blank2_d;
            sel2_q        <= sel2_d;
            vid2_q        <= vid2_d;
            rgb_q         <= rgb_d;
            pixel_hit_q   <= pixel_hit_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign rom_char  = rom_char_q;
    assign rom_row   = rom_row_q;
    assign rgb_out   = rgb_q;
    assign pixel_hit = pixel_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_field_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_field_renderer
//  Description : Self-checking bench for bcd_field_renderer. Two instances
//                (scale 2 with blinking, scale 4 with leading-zero blanking)
//                share stimulus; a behavioural model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_field_renderer;

    localparam logic [11:0] c_fg = 12'hFFF;
    localparam logic [11:0] c_hl = 12'hF00;
    localparam logic [11:0] c_bg = 12'h000;
    localparam int          c_bf_a = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        video_on = 1'b0;
    logic        prog_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pixel_x = 10'd0;
    logic [9:0]  pixel_y = 10'd0;
    logic [3:0]  cursor = 4'd0;
    logic [23:0] digits = 24'd0;

    logic [3:0]  rom_char_a, rom_row_a, rom_char_b, rom_row_b;
    logic [7:0]  rom_data_a = 8'd0;
    logic [7:0]  rom_data_b = 8'd0;
    logic [11:0] rgb_out_a, rgb_out_b;
    logic        pixel_hit_a, pixel_hit_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // bench-side stimulus state
    bit          rst_v = 1'b1;
    bit          en_v = 1'b1;
    bit          vid_v = 1'b1;
    bit          pg_v = 1'b0;
    bit          tick_v = 1'b0;
    int          cur_v = 0;
    logic [23:0] dig_v = 24'h123456;
    int          m_ticks = 0;

    logic [12:0] exp_a [8];
    logic [12:0] exp_b [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_field_renderer #(
        .BLINK_FRAMES (c_bf_a)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .video_on   (video_on),
        .prog_on    (prog_on),
        .frame_tick (frame_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .cursor     (cursor),
        .digits     (digits),
        .rom_char   (rom_char_a),
        .rom_row    (rom_row_a),
        .rom_data   (rom_data_a),
        .rgb_out    (rgb_out_a),
        .pixel_hit  (pixel_hit_a)
    );

    bcd_field_renderer #(
        .NUM_FIELDS   (3),
        .X0           (40),
        .Y0           (20),
        .SCALE        (4),
        .FIELD_PITCH  (70),
        .CURSOR_BASE  (0),
        .BLINK_FRAMES (0),
        .LZ_BLANK     (1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .video_on   (video_on),
        .prog_on    (prog_on),
        .frame_tick (frame_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .cursor     (cursor),
        .digits     (digits),
        .rom_char   (rom_char_b),
        .rom_row    (rom_row_b),
        .rom_data   (rom_data_b),
        .rgb_out    (rgb_out_b),
        .pixel_hit  (pixel_hit_b)
    );

    // Arbitrary but fixed font: any row pattern works as long as ROM and model agree.
    function automatic logic [7:0] font(input logic [3:0] ch, input logic [3:0] row);
        int v;
        v = ((int'(ch) + 1) * 73 + int'(row) * 29) ^ (int'(row) * int'(ch) * 5);
        return 8'(v);
    endfunction

    // Synchronous font ROMs: data valid one clock after the address.
    always @(posedge clk) begin
        rom_data_a <= font(rom_char_a, rom_row_a);
        rom_data_b <= font(rom_char_b, rom_row_b);
    end

    // Behavioural pixel model: returns {pixel_hit, rgb}.
    function automatic logic [12:0] model(input int x, input int y, input logic [23:0] dg,
                                          input bit vid, input bit en, input bit pg, input int cur,
                                          input bit ph, input int x0, input int y0, input int sc,
                                          input int pitch, input int cb, input bit lz);
        int dx, k, w, d, col, row, val;
        logic [7:0] f;
        if (!en || !vid || x < x0 || y < y0 || y >= y0 + 16 * sc) return 13'h0;
        dx = x - x0;
        k  = dx / pitch;
        w  = dx % pitch;
        if (k >= 3 || w >= 16 * sc) return 13'h0;
        d   = w / (8 * sc);
        col = (w % (8 * sc)) / sc;
        row = (y - y0) / sc;
        val = int'((dg >> (8 * k + ((d == 0) ? 4 : 0))) & 24'hF);
        if (val > 9 || (lz && k == 0 && d == 0 && val == 0)) return {1'b1, c_bg};
        f = font(4'(val), 4'(row));
        if (!f[7 - col]) return {1'b1, c_bg};
        if (pg && cur == cb + k && !ph) return {1'b1, c_hl};
        return {1'b1, c_fg};
    endfunction

    function automatic logic [12:0] model_a(input int x, input int y, input logic [23:0] dg,
                                            input bit vid, input bit en, input bit pg,
                                            input int cur, input bit ph);
        return model(x, y, dg, vid, en, pg, cur, ph, 304, 384, 2, 48, 6, 1'b0);
    endfunction

    function automatic logic [12:0] model_b(input int x, input int y, input logic [23:0] dg,
                                            input bit vid, input bit en, input bit pg, input int cur);
        return model(x, y, dg, vid, en, pg, cur, 1'b0, 40, 20, 4, 70, 0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, want, $time);
        end
    endtask

    // Drive one pixel per clock and record the expected output three clocks later.
    task automatic step(input int x, input int y);
        logic [2:0] s;
        bit ph;
        @(posedge clk);
        #1;
        reset      = rst_v;
        enable     = en_v;
        video_on   = vid_v;
        prog_on    = pg_v;
        frame_tick = tick_v;
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        cursor     = 4'(cur_v);
        digits     = dig_v;
        s = 3'(cyc);
        if (rst_v) begin
            exp_a[s] = 13'h0;  exp_b[s] = 13'h0;
            exp_a[3'(cyc + 7)] = 13'h0;  exp_b[3'(cyc + 7)] = 13'h0;
            exp_a[3'(cyc + 6)] = 13'h0;  exp_b[3'(cyc + 6)] = 13'h0;
            m_ticks = 0;
        end else begin
            ph = ((m_ticks / c_bf_a) % 2) == 1;
            exp_a[s] = model_a(x, y, dig_v, vid_v, en_v, pg_v, cur_v, ph);
            exp_b[s] = model_b(x, y, dig_v, vid_v, en_v, pg_v, cur_v);
            if (!pg_v) m_ticks = 0;
            else if (tick_v) m_ticks++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic scan(input int y, input int xa, input int xb);
        for (int x = xa; x <= xb; x++) step(x, y);
    endtask

    task automatic tick();
        idle(3);
        tick_v = 1'b1;
        step(0, 0);
        tick_v = 1'b0;
    endtask

    task automatic set_prog(input bit v);
        idle(3);
        pg_v = v;
        step(0, 0);
    endtask

    // Compare both instances against the model every cycle once out of reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pix_a", 32'({pixel_hit_a, rgb_out_a}), 32'(exp_a[3'(cyc + 5)]));
            check("pix_b", 32'({pixel_hit_b, rgb_out_b}), 32'(exp_b[3'(cyc + 5)]));
        end
    end

    initial begin
        // model pins, hand-computed from the font table
        check("pin_f0_tens5_c0", 32'(model_a(304, 384, 24'h123456, 1, 1, 0, 0, 0)), 32'h1FFF);
        check("pin_f0_tens5_c1", 32'(model_a(306, 384, 24'h123456, 1, 1, 0, 0, 0)), 32'h1000);
        check("pin_gap",         32'(model_a(336, 384, 24'h123456, 1, 1, 0, 0, 0)), 32'h0000);
        check("pin_f1_u4_r1c0",  32'(model_a(368, 386, 24'h123456, 1, 1, 0, 0, 0)), 32'h1FFF);
        check("pin_f1_u4_r1c1",  32'(model_a(370, 386, 24'h123456, 1, 1, 0, 0, 0)), 32'h1000);
        check("pin_hl_sel",      32'(model_a(356, 384, 24'h123456, 1, 1, 1, 7, 0)), 32'h1F00);
        check("pin_hl_phase1",   32'(model_a(356, 384, 24'h123456, 1, 1, 1, 7, 1)), 32'h1FFF);
        check("pin_hl_othercur", 32'(model_a(356, 384, 24'h123456, 1, 1, 1, 6, 0)), 32'h1FFF);
        check("pin_bx303", 32'(model_a(303, 384, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd0);
        check("pin_bx304", 32'(model_a(304, 384, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd1);
        check("pin_bx319", 32'(model_a(319, 384, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd1);
        check("pin_bx320", 32'(model_a(320, 384, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd1);
        check("pin_by383", 32'(model_a(304, 383, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd0);
        check("pin_by415", 32'(model_a(304, 415, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd1);
        check("pin_by416", 32'(model_a(304, 416, 24'h123456, 1, 1, 0, 0, 0) >> 12), 32'd0);

        // reset
        rst_v = 1'b1;
        idle(5);
        check("rst_rgb_a",  32'(rgb_out_a), 32'd0);
        check("rst_hit_a",  32'(pixel_hit_a), 32'd0);
        check("rst_char_a", 32'(rom_char_a), 32'd0);
        check("rst_row_a",  32'(rom_row_a), 32'd0);
        chk_en = 1'b1;
        rst_v  = 1'b0;
        idle(4);

        // plain render of both instances
        dig_v = 24'h123456;
        scan(390, 300, 435);
        scan(60, 36, 250);
        scan(384, 300, 431);
        idle(3);
        check("hold_char_a", 32'(rom_char_a), 32'd2);
        check("hold_row_a",  32'(rom_row_a), 32'd0);

        // blinking highlight on field 1
        cur_v = 7;
        set_prog(1'b1);
        for (int f = 0; f < 5; f++) begin
            scan(384, 304, 431);
            tick();
        end

        // prog_on dropped mid-blink clears the counter
        set_prog(1'b0);
        set_prog(1'b1);
        tick();
        set_prog(1'b0);
        set_prog(1'b1);
        tick();
        scan(384, 350, 385);
        tick();
        scan(384, 350, 385);
        set_prog(1'b0);

        // invalid and leading-zero digits
        dig_v = 24'h34560A;
        scan(386, 300, 340);
        scan(30, 36, 110);
        dig_v = 24'h345605;
        scan(30, 36, 110);
        scan(386, 300, 340);

        // video_on low, enable low
        dig_v = 24'h123456;
        vid_v = 1'b0;
        scan(384, 304, 340);
        vid_v = 1'b1;
        en_v  = 1'b0;
        scan(384, 304, 340);
        en_v  = 1'b1;
        idle(3);

        // boundaries
        step(303, 384); step(304, 384); step(319, 384); step(320, 384);
        step(304, 383); step(304, 415); step(304, 416);
        step(1023, 1023); step(0, 1023);
        idle(3);

        // reset mid-glyph
        scan(384, 304, 330);
        rst_v = 1'b1;
        step(331, 384);
        rst_v = 1'b0;
        step(332, 384);
        check("mid_rst_rgb_a",  32'(rgb_out_a), 32'd0);
        check("mid_rst_hit_a",  32'(pixel_hit_a), 32'd0);
        check("mid_rst_char_a", 32'(rom_char_a), 32'd0);
        check("mid_rst_row_a",  32'(rom_row_a), 32'd0);
        check("mid_rst_rgb_b",  32'(rgb_out_b), 32'd0);
        check("mid_rst_hit_b",  32'(pixel_hit_b), 32'd0);
        scan(384, 333, 380);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0)  dig_v = 24'($urandom);
            if (n % 400 == 0) set_prog(1'($urandom));
            if (n % 150 == 75) tick();
            cur_v = int'($urandom_range(0, 15));
            vid_v = ($urandom_range(0, 9) != 0);
            en_v  = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 4))
                0, 1:    step(int'($urandom_range(300, 440)), int'($urandom_range(380, 420)));
                2, 3:    step(int'($urandom_range(36, 255)), int'($urandom_range(16, 90)));
                default: step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            endcase
        end
        vid_v = 1'b1;
        en_v  = 1'b1;
        idle(4);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
